linear_ccd_ctrl: RTL and testbench

Sequencer for a TSL1401-style 128-pixel linear CCD and its ADC, clocked by cam_clk. It generates the sensor SI and CCD clock and sequences one ADC conversion per pixel. Captured pixels stream out with index, and an optional exposure gap follows each readout. It replaces the free-running fixed-period SI generator with a start/continuous-controlled frame engine feeding the image line buffer.

---
 rtl/ccd_pkg.sv | 19 +
 rtl/ccd_clk_div.sv | 43 ++++
 rtl/linear_ccd_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_linear_ccd_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared types and default dimensions for the linear CCD frame sequencer.
package ccd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_CLK_HI   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_CLK_LO   = 3'd4,
    ST_EXPOSE   = 3'd5,
    ST_DONE     = 3'd6
  } ccd_state_e;

  localparam int PIX_N_DEF       = 128;
  localparam int CLK_DIV_DEF     = 2;
  localparam int ADC_TIMEOUT_DEF = 64;
  localparam int IDX_W           = $clog2(PIX_N_DEF);

endpackage

// File: rtl/ccd_clk_div.sv
// Half-period counter for the CCD clock: flags the last and next-to-last cycle
// of each phase; hold_i parks the counter at zero (idle, done, ADC stretch).
module ccd_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic cam_clk,
  input  logic rst_n,
  input  logic hold_i,
  output logic pre_end_o,
  output logic phase_end_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV - 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at the end of each half-period.
  always_comb begin
    if (hold_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pre_end_o   = !hold_i && (cnt_q == CNT_PRE);
  assign phase_end_o = !hold_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/linear_ccd_ctrl.sv
// Frame sequencer for a 128-pixel linear CCD plus its ADC (SI, CCD clock, one
// conversion per pixel). Define CCD_MINMAX_EN to add per-frame min/max outputs.
module linear_ccd_ctrl
  import ccd_pkg::*;
#(
  parameter int PIX_N       = PIX_N_DEF,
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int ADC_W       = 8,
  parameter int ADC_TIMEOUT = ADC_TIMEOUT_DEF,
  parameter int EXP_W       = 16
) (
  input  logic             cam_clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic             ccd_si_o,
  output logic             ccd_clk_o,
  output logic             adc_req_o,
  input  logic             adc_ack_i,
  input  logic [ADC_W-1:0] adc_data_i,
  output logic             pix_valid_o,
  output logic [IDX_W-1:0] pix_idx_o,
  output logic [ADC_W-1:0] pix_data_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic             adc_err_o
`ifdef CCD_MINMAX_EN
  ,
  output logic [ADC_W-1:0] frame_min_o,
  output logic [ADC_W-1:0] frame_max_o
`endif
);

  localparam int N_W  = $clog2(PIX_N + 2);
  localparam int WT_W = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
  localparam logic [N_W-1:0]  N_LAST   = N_W'(PIX_N);
  localparam logic [WT_W-1:0] WT_LAST  = WT_W'(ADC_TIMEOUT - 1);
  localparam logic [EXP_W:0]  HALF_ONE = (EXP_W + 1)'(1);

  ccd_state_e       state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [WT_W-1:0]  wcnt_q, wcnt_d;
  logic [EXP_W:0]   half_q, half_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             si_q, si_d, clk_q, clk_d, req_q, req_d;
  logic             valid_q, valid_d, done_q, done_d, busy_q, busy_d, err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic             hold_s, pre_end_s, phase_end_s;

  assign hold_s = (state_q == ST_IDLE) || (state_q == ST_WAIT_ACK) || (state_q == ST_DONE);

  ccd_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .cam_clk     (cam_clk),
    .rst_n       (rst_n),
    .hold_i      (hold_s),
    .pre_end_o   (pre_end_s),
    .phase_end_o (phase_end_s)
  );

  // Next-state and registered-output logic of the frame engine.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    half_d  = half_q;
    exp_d   = exp_q;
    req_d   = 1'b0;
    valid_d = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SETUP;
          exp_d   = exp_i;
          err_d   = 1'b0;
          n_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (phase_end_s) state_d = ST_CLK_HI;
        else             state_d = ST_SETUP;
      end
      ST_CLK_HI: begin
        // Request is registered, so raise it one cycle ahead of the phase end.
        if (pre_end_s && (n_q < N_LAST)) req_d = 1'b1;
        else                             req_d = 1'b0;
        if (!phase_end_s) begin
          state_d = ST_CLK_HI;
        end else if (n_q == N_LAST) begin
          state_d = ST_CLK_LO;
        end else if (adc_ack_i) begin
          state_d = ST_CLK_LO;
          valid_d = 1'b1;
          idx_d   = n_q[IDX_W-1:0];
          data_d  = adc_data_i;
        end else begin
          state_d = ST_WAIT_ACK;
          wcnt_d  = '0;
        end
      end
      ST_WAIT_ACK: begin
        if (adc_ack_i) begin
          state_d = ST_CLK_LO;
          valid_d = 1'b1;
          idx_d   = n_q[IDX_W-1:0];
          data_d  = adc_data_i;
        end else if (wcnt_q == WT_LAST) begin
          state_d = ST_CLK_LO;
          valid_d = 1'b1;
          idx_d   = n_q[IDX_W-1:0];
          data_d  = '0;
          err_d   = 1'b1;
        end else begin
          wcnt_d  = wcnt_q + WT_W'(1);
        end
      end
      ST_CLK_LO: begin
        if (!phase_end_s) begin
          state_d = ST_CLK_LO;
        end else begin
          n_d = n_q + N_W'(1);
          if (n_q < N_LAST) begin
            state_d = ST_CLK_HI;
          end else if (exp_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EXPOSE;
            half_d  = {exp_q, 1'b0};
          end
        end
      end
      ST_EXPOSE: begin
        // half_q counts remaining CCD half-periods of the exposure gap.
        if (!phase_end_s)            state_d = ST_EXPOSE;
        else if (half_q == HALF_ONE) state_d = ST_DONE;
        else                         half_d  = half_q - HALF_ONE;
      end
      ST_DONE: begin
        if (cont_i) begin
          state_d = ST_SETUP;
          exp_d   = exp_i;
          err_d   = 1'b0;
          n_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    si_d   = (state_d == ST_SETUP) ||
             (((state_d == ST_CLK_HI) || (state_d == ST_WAIT_ACK)) && (n_d == '0));
    clk_d  = (state_d == ST_CLK_HI) || (state_d == ST_WAIT_ACK);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Frame engine state and output registers.
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      half_q  <= '0;
      exp_q   <= '0;
      si_q    <= 1'b0;
      clk_q   <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      half_q  <= half_d;
      exp_q   <= exp_d;
      si_q    <= si_d;
      clk_q   <= clk_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign ccd_si_o     = si_q;
  assign ccd_clk_o    = clk_q;
  assign adc_req_o    = req_q;
  assign pix_valid_o  = valid_q;
  assign pix_idx_o    = idx_q;
  assign pix_data_o   = data_q;
  assign frame_done_o = done_q;
  assign busy_o       = busy_q;
  assign adc_err_o    = err_q;

`ifdef CCD_MINMAX_EN
  logic [ADC_W-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
  logic [ADC_W-1:0] fmin_q, fmin_d, fmax_q, fmax_d;

  // Running extremes restart on every SETUP entry and publish on DONE.
  always_comb begin
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) begin
      run_min_d = {ADC_W{1'b1}};
      run_max_d = '0;
    end else if (valid_d) begin
      run_min_d = (data_d < run_min_q) ? data_d : run_min_q;
      run_max_d = (data_d > run_max_q) ? data_d : run_max_q;
    end else begin
      run_min_d = run_min_q;
    end
    if (state_d == ST_DONE) begin
      fmin_d = run_min_q;
      fmax_d = run_max_q;
    end else begin
      fmin_d = fmin_q;
      fmax_d = fmax_q;
    end
  end

  // Min/max registers.
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min_q <= '0;
      run_max_q <= '0;
      fmin_q    <= '0;
      fmax_q    <= '0;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      fmin_q    <= fmin_d;
      fmax_q    <= fmax_d;
    end
  end

  assign frame_min_o = fmin_q;
  assign frame_max_o = fmax_q;
`endif

endmodule

// File: tb/tb_linear_ccd_ctrl.sv
// Randomized bench for linear_ccd_ctrl: an ADC responder with per-pixel latency
// and an arithmetic frame-timing model derived from the phase lengths.
`timescale 1ns/1ps
module tb_linear_ccd_ctrl;

  localparam int PIX_N = 128;
  localparam int CD    = 2;
  localparam int ADC_W = 8;
  localparam int TO    = 64;
  localparam int EXP_W = 16;

  logic             cam_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic             cont_i = 1'b0;
  logic [EXP_W-1:0] exp_i = '0;
  logic             adc_ack_i = 1'b0;
  logic [ADC_W-1:0] adc_data_i = '0;
  logic             ccd_si_o, ccd_clk_o, adc_req_o, pix_valid_o;
  logic [6:0]       pix_idx_o;
  logic [ADC_W-1:0] pix_data_o;
  logic             frame_done_o, busy_o, adc_err_o;
`ifdef CCD_MINMAX_EN
  logic [ADC_W-1:0] frame_min_o, frame_max_o;
`endif

  linear_ccd_ctrl #(.PIX_N(PIX_N), .CLK_DIV(CD), .ADC_W(ADC_W),
                    .ADC_TIMEOUT(TO), .EXP_W(EXP_W)) dut (
    .cam_clk(cam_clk), .rst_n(rst_n), .start_i(start_i), .cont_i(cont_i),
    .exp_i(exp_i), .ccd_si_o(ccd_si_o), .ccd_clk_o(ccd_clk_o),
    .adc_req_o(adc_req_o), .adc_ack_i(adc_ack_i), .adc_data_i(adc_data_i),
    .pix_valid_o(pix_valid_o), .pix_idx_o(pix_idx_o), .pix_data_o(pix_data_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o), .adc_err_o(adc_err_o)
`ifdef CCD_MINMAX_EN
    , .frame_min_o(frame_min_o), .frame_max_o(frame_max_o)
`endif
  );

  always #5 cam_clk = ~cam_clk;

  int n_checks = 0;
  int n_errors = 0;
  int lat [PIX_N];   // ack latency per pixel in cycles; > TO means timeout
  int val [PIX_N];
  int req_n = 0;
  int wait_left = -1;
  int ack_pix = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ADC model: acks lat[] cycles after each request, random junk otherwise.
  always @(negedge cam_clk) begin
    adc_ack_i  = 1'b0;
    adc_data_i = ADC_W'($urandom);
    if (!rst_n) begin
      wait_left = -1;
    end else begin
      if (adc_req_o) begin
        ack_pix   = req_n;
        wait_left = (req_n < PIX_N) ? lat[req_n] : -1;
        req_n++;
      end else if (wait_left > 0) begin
        wait_left--;
      end
      if (wait_left == 0) begin
        adc_ack_i  = 1'b1;
        adc_data_i = ADC_W'(val[ack_pix]);
        wait_left  = -1;
      end
    end
  end

  task automatic set_frame(input int lat_max, input bit ramp, input int base);
    for (int n = 0; n < PIX_N; n++) begin
      lat[n] = (lat_max == 0) ? 0 : int'($urandom_range(0, lat_max));
      val[n] = ramp ? (base + n) : int'($urandom_range(0, 255));
    end
  endtask

  task automatic start_frame();
    req_n   = 0;
    start_i = 1'b1;
    @(negedge cam_clk);
    start_i = 1'b0;
  endtask

  // Called at the negedge of the first SETUP cycle; returns at the DONE cycle.
  task automatic run_frame(input string nm, input int exp_v, input int abort_pix,
                           input int start_poke, input int exp_next);
    int st [PIX_N+1];
    int hi_exp [PIX_N+1];
    int vc_exp [PIX_N];
    int acc, len, rises, rise_bad, si_cnt, si_last, busy_low, done_cyc;
    bit miss, prev_clk, err_end;
    int got_idx [$];
    int got_dat [$];
    int got_cyc [$];
    miss = 1'b0;
    acc  = 1 + CD;
    for (int n = 0; n <= PIX_N; n++) begin
      st[n] = (n == PIX_N) ? 0 : ((lat[n] > TO) ? TO : lat[n]);
      if (n < PIX_N && lat[n] > TO) miss = 1'b1;
      hi_exp[n] = acc;
      if (n < PIX_N) vc_exp[n] = acc + CD + st[n];
      acc += 2 * CD + st[n];
    end
    len = acc - 1 + 2 * exp_v * CD;
    chk({nm, "_err_clr"}, adc_err_o, 0);
    chk({nm, "_si_setup"}, ccd_si_o, 1);
    rises = 0; rise_bad = 0; si_cnt = 0; si_last = 0; busy_low = 0;
    done_cyc = -1; prev_clk = 1'b0; err_end = 1'b0;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      start_i = (cyc == start_poke);
      if (cyc == 10 && exp_next >= 0) exp_i = EXP_W'(exp_next);
      if (ccd_clk_o && !prev_clk) begin
        if (rises <= PIX_N && cyc != hi_exp[rises]) rise_bad++;
        rises++;
      end
      prev_clk = ccd_clk_o;
      if (ccd_si_o) begin si_cnt++; si_last = cyc; end
      if (!busy_o) busy_low++;
      if (pix_valid_o) begin
        got_idx.push_back(int'(pix_idx_o));
        got_dat.push_back(int'(pix_data_o));
        got_cyc.push_back(cyc);
        if (abort_pix >= 0 && int'(pix_idx_o) == abort_pix) begin
          rst_n = 1'b0;
          #1;
          chk({nm, "_rst_si"}, ccd_si_o, 0);
          chk({nm, "_rst_clk"}, ccd_clk_o, 0);
          chk({nm, "_rst_req"}, adc_req_o, 0);
          chk({nm, "_rst_valid"}, pix_valid_o, 0);
          chk({nm, "_rst_idx"}, pix_idx_o, 0);
          chk({nm, "_rst_data"}, pix_data_o, 0);
          chk({nm, "_rst_done"}, frame_done_o, 0);
          chk({nm, "_rst_busy"}, busy_o, 0);
          chk({nm, "_rst_err"}, adc_err_o, 0);
          chk({nm, "_rst_pixcnt"}, got_idx.size(), abort_pix + 1);
          start_i = 1'b0;
          return;
        end
      end
      if (frame_done_o) begin
        done_cyc = cyc;
        err_end  = adc_err_o;
        break;
      end
      @(negedge cam_clk);
    end
    start_i = 1'b0;
    chk({nm, "_done_cycle"}, done_cyc, len + 1);
    chk({nm, "_clk_rises"}, rises, PIX_N + 1);
    chk({nm, "_rise_timing_bad"}, rise_bad, 0);
    chk({nm, "_si_cycles"}, si_cnt, 2 * CD + st[0]);
    chk({nm, "_si_last"}, si_last, 2 * CD + st[0]);
    chk({nm, "_busy_low"}, busy_low, 0);
    chk({nm, "_adc_err"}, err_end, miss);
    chk({nm, "_pix_count"}, got_idx.size(), PIX_N);
    for (int n = 0; n < got_idx.size() && n < PIX_N; n++) begin
      chk($sformatf("%s_pix%0d_idx", nm, n), got_idx[n], n);
      chk($sformatf("%s_pix%0d_data", nm, n), got_dat[n], (lat[n] > TO) ? 0 : val[n]);
      chk($sformatf("%s_pix%0d_cyc", nm, n), got_cyc[n], vc_exp[n]);
    end
  endtask

  task automatic idle_check(input string nm, input int ncyc);
    int busy_hi = 0;
    int clk_hi = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge cam_clk);
      if (busy_o) busy_hi++;
      if (ccd_clk_o || ccd_si_o) clk_hi++;
    end
    chk({nm, "_idle_busy"}, busy_hi, 0);
    chk({nm, "_idle_sensor"}, clk_hi, 0);
  endtask

  initial begin
    int e2;
    repeat (3) @(negedge cam_clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_clk", ccd_clk_o, 0);
    chk("reset_si", ccd_si_o, 0);
    chk("reset_valid", pix_valid_o, 0);
    chk("reset_done", frame_done_o, 0);
    chk("reset_err", adc_err_o, 0);
    rst_n = 1'b1;
    idle_check("pre", 3);

    // Baseline: zero-stretch acks, data equals index.
    set_frame(0, 1'b1, 0);
    start_frame();
    run_frame("f1", 0, -1, -1, -1);
    idle_check("f1", 4);

    // Every ack 5 cycles late.
    set_frame(0, 1'b0, 0);
    for (int n = 0; n < PIX_N; n++) lat[n] = 5;
    start_frame();
    run_frame("f2", 0, -1, -1, -1);
    idle_check("f2", 2);

    // Pixel 17 never acked in time; the late ack lands in CLK_LO.
    set_frame(0, 1'b0, 0);
    lat[17] = TO + 1;
    val[17] = 8'hA5;
    start_frame();
    run_frame("f3", 0, -1, -1, -1);
    @(negedge cam_clk);
    chk("f3_err_sticky", adc_err_o, 1);
    idle_check("f3", 2);

    // Continuous pair: exp 3 then a re-latched random gap; stray start mid-frame.
    e2 = int'($urandom_range(0, 4));
    set_frame(0, 1'b0, 0);
    exp_i  = 16'd3;
    cont_i = 1'b1;
    start_frame();
    run_frame("f4a", 3, -1, -1, e2);
    @(negedge cam_clk);
    cont_i = 1'b0;
    req_n  = 0;
    set_frame(3, 1'b0, 0);
    run_frame("f4b", e2, -1, 40, -1);
    idle_check("f4b", 6);

    // Reset in mid-frame at pixel 40 after an earlier timeout and a stray start.
    set_frame(0, 1'b0, 0);
    lat[3] = TO + 1;
    exp_i  = 16'd0;
    start_frame();
    run_frame("f5", 0, 40, 30, -1);
    @(negedge cam_clk);
    chk("f5_rst_hold_busy", busy_o, 0);
    rst_n = 1'b1;
    idle_check("f5", 3);

    // Clean frame after reset: ramp 10..137, exp 1.
    set_frame(0, 1'b1, 10);
    exp_i = 16'd1;
    start_frame();
    run_frame("f6", 1, -1, -1, -1);
`ifdef CCD_MINMAX_EN
    chk("f6_min", frame_min_o, 10);
    chk("f6_max", frame_max_o, 137);
`endif
    idle_check("f6", 2);

    // Fully random frame.
    set_frame(6, 1'b0, 0);
    e2 = int'($urandom_range(0, 2));
    exp_i = EXP_W'(e2);
    start_frame();
    run_frame("f7", e2, -1, -1, -1);
    idle_check("f7", 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
